// File: rtl/tcnt_delay_timer.sv
// Multi-channel programmable delay engine with shared tick prescaler,
// free-running timestamp and a 32-bit Galois LFSR for random delays.
// Each channel: IDLE -> LOAD -> COUNT -> FIRE -> IDLE; FIRE is the done cycle.
// Random span is computed modulo a 32-bit LFSR value, so DLY_W must be <= 31.
module tcnt_delay_timer #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DLY_W     = 16,
  parameter int unsigned TS_W      = 48,
  parameter int unsigned TICK_DIV  = 1000,
  parameter logic [31:0] LFSR_SEED = 32'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start_vld,
  output logic [NUM_CH-1:0]       start_rdy,
  input  logic [NUM_CH*DLY_W-1:0] start_min,
  input  logic [NUM_CH*DLY_W-1:0] start_max,
  input  logic [NUM_CH-1:0]       start_rand,
  input  logic [NUM_CH-1:0]       abort,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  input  logic                    ts_clr,
  output logic                    tick,
  output logic [TS_W-1:0]         timestamp
);

  localparam int unsigned   PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, FIRE} state_t;

  logic [1:0]    rst_sync;
  logic          rst_int;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [31:0]   lfsr;

  // Reset synchroniser: asserts asynchronously, releases on the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int = rst_sync[1];

  // Next prescaler value; wraps at TICK_DIV-1 (stays 0 when TICK_DIV=1).
  always_comb begin
    presc_nxt = (presc == PMAX) ? '0 : presc + PW'(1);
  end

  // Prescaler with registered tick: tick is high while presc sits at PMAX.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_nxt;
      tick  <= (presc_nxt == PMAX);
    end
  end

  // Timestamp in ticks; clear beats a coincident tick.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int)    timestamp <= '0;
    else if (ts_clr) timestamp <= '0;
    else if (tick)   timestamp <= timestamp + TS_W'(1);
  end

  // Galois LFSR, polynomial x^32+x^22+x^2+x+1, stepping every cycle.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int)     lfsr <= LFSR_SEED;
    else if (lfsr[0]) lfsr <= (lfsr >> 1) ^ 32'h8020_0003;
    else              lfsr <= lfsr >> 1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] min_q;
    logic [DLY_W-1:0] max_q;
    logic             rand_q;
    logic             busy_q;
    logic             done_q;
    logic [DLY_W:0]   span;
    logic [31:0]      rnd;
    logic [DLY_W-1:0] target;

    // Delay target for LOAD; span forced to 1 when unused so the modulo is always defined.
    always_comb begin
      rnd    = lfsr ^ 32'(c);
      span   = (max_q > min_q) ? ({1'b0, max_q} - {1'b0, min_q} + (DLY_W+1)'(1))
                               : (DLY_W+1)'(1);
      target = min_q;
      if (rand_q && (max_q > min_q))
        target = min_q + DLY_W'(rnd % 32'(span));
    end

    // Channel FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
        state  <= IDLE;
        cnt    <= '0;
        min_q  <= '0;
        max_q  <= '0;
        rand_q <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            done_q <= 1'b0;
            if (start_vld[c]) begin
              min_q  <= start_min[c*DLY_W +: DLY_W];
              max_q  <= start_max[c*DLY_W +: DLY_W];
              rand_q <= start_rand[c];
              busy_q <= 1'b1;
              state  <= LOAD;
            end
          end
          LOAD: begin
            if (abort[c]) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              cnt <= target;
              if (target == '0) begin
                done_q <= 1'b1;
                state  <= FIRE;
              end else begin
                state  <= COUNT;
              end
            end
          end
          COUNT: begin
            if (abort[c]) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else if (tick) begin
              // Expiring on the last tick here lets done appear the cycle after it.
              if (cnt == DLY_W'(1)) begin
                cnt    <= '0;
                done_q <= 1'b1;
                state  <= FIRE;
              end else begin
                cnt <= cnt - DLY_W'(1);
              end
            end
          end
          FIRE: begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end

    assign start_rdy[c] = (state == IDLE);
    assign busy[c]      = busy_q;
    assign done[c]      = done_q;
  end

endmodule

// File: tb/tb_tcnt_delay_timer.sv
// Directed bench for tcnt_delay_timer (4 channels, TICK_DIV=4, TS_W=8).
// Cycle index cyc is 0 on the first cycle the DUT leaves its internal reset.
module tb_tcnt_delay_timer;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int TW  = 8;
  localparam int TD  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    start_vld, start_rdy, start_rand, abort, busy, done;
  logic [NCH*DW-1:0] start_min, start_max;
  logic              ts_clr, tick;
  logic [TW-1:0]     timestamp;

  tcnt_delay_timer #(.NUM_CH(NCH), .DLY_W(DW), .TS_W(TW), .TICK_DIV(TD),
                     .LFSR_SEED(32'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start_vld(start_vld), .start_rdy(start_rdy),
    .start_min(start_min), .start_max(start_max), .start_rand(start_rand),
    .abort(abort), .busy(busy), .done(done), .ts_clr(ts_clr), .tick(tick),
    .timestamp(timestamp));

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= -2;
    else        cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int dcyc[NCH];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_tick(input int n);
    return (n >= 0) && (n % TD == TD - 1);
  endfunction

  function automatic int ticks_in(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (is_tick(k)) n++;
    return n;
  endfunction

  // Handshake in cycle s: LOAD in s+1, counting ticks from s+2, done the cycle after the d-th.
  function automatic int exp_done(input int s, input int d);
    int k = s + 1;
    int n = 0;
    if (d == 0) return s + 2;
    while (n < d) begin
      k++;
      if (is_tick(k)) n++;
    end
    return k + 1;
  endfunction

  task automatic start(input logic [NCH-1:0] mask, input int mn, input int mx,
                       input logic rnd, input logic abt, output int s);
    logic [DW-1:0] mn_v, mx_v;
    mn_v = mn[DW-1:0];
    mx_v = mx[DW-1:0];
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        chk("rdy_before_start", start_rdy[c], 1);
        start_min[c*DW +: DW] = mn_v;
        start_max[c*DW +: DW] = mx_v;
      end
    end
    start_vld  = mask;
    start_rand = rnd ? mask : '0;
    abort      = abt ? mask : '0;
    s = cyc;
    @(negedge clk);
    start_vld = '0;
    abort     = '0;
  endtask

  task automatic wait_done(input int ch);
    int d_cyc = -1;
    int busy_bad = 0;
    int ex;
    if (!busy[ch]) busy_bad++;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy[ch]) busy_bad++;
      if (done[ch]) begin
        d_cyc = cyc;
        break;
      end
    end
    ex = exp_q.pop_front();
    chk("done_cycle", d_cyc, ex);
    chk("busy_hold", busy_bad, 0);
    chk("rdy_low_in_done_cycle", start_rdy[ch], 0);
    @(negedge clk);
    chk("done_one_cycle", done[ch], 0);
    chk("rdy_after_done", start_rdy[ch], 1);
  endtask

  task automatic collect(input logic [NCH-1:0] mask, input int budget);
    bit pending;
    for (int c = 0; c < NCH; c++) dcyc[c] = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      pending = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (mask[c] && dcyc[c] < 0 && done[c]) dcyc[c] = cyc;
        if (mask[c] && dcyc[c] < 0) pending = 1'b1;
      end
      if (!pending) break;
    end
    @(negedge clk);
  endtask

  initial begin
    int s, c0, bad, bad2, d, nhit, ok;
    int dv[NCH];
    bit [10:0] hit;

    rst_n = 1'b0; start_vld = '0; start_rand = '0; abort = '0;
    start_min = '0; start_max = '0; ts_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rdy", start_rdy, 4'hF);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tick", tick, 0);
    chk("reset_ts", timestamp, 0);
    rst_n = 1'b1;

    // Prescaler/timestamp model against the full 8-bit wrap.
    bad = 0; bad2 = 0;
    while (cyc < 1024) begin
      @(negedge clk);
      if (cyc >= 0) begin
        if (tick !== is_tick(cyc)) bad++;
        if (int'(timestamp) != (cyc / TD) % 256) bad2++;
        if (cyc == 1020) chk("ts_before_wrap", timestamp, 255);
      end
    end
    chk("tick_pattern", bad, 0);
    chk("ts_count", bad2, 0);
    chk("ts_wrapped", timestamp, 0);

    // Clear coincident with a tick.
    while (!is_tick(cyc)) @(negedge clk);
    ts_clr = 1'b1; c0 = cyc;
    @(negedge clk);
    ts_clr = 1'b0;
    chk("ts_clr_wins", timestamp, 0);
    repeat (3) @(negedge clk);
    chk("ts_hold_after_clr", timestamp, 0);
    @(negedge clk);
    chk("ts_after_next_tick", timestamp, 1);
    chk("clr_cycle_ref", cyc, c0 + 5);

    // Fixed delay on ch1.
    start(4'b0010, 3, 0, 1'b0, 1'b0, s);
    exp_q.push_back(exp_done(s, 3));
    wait_done(1);

    // Degenerate random ranges collapse to min.
    start(4'b0100, 7, 7, 1'b1, 1'b0, s);
    exp_q.push_back(exp_done(s, 7));
    wait_done(2);
    start(4'b0100, 7, 5, 1'b1, 1'b0, s);
    exp_q.push_back(exp_done(s, 7));
    wait_done(2);

    // Zero delay: done two cycles after the handshake cycle.
    start(4'b0001, 0, 0, 1'b0, 1'b0, s);
    exp_q.push_back(s + 2);
    wait_done(0);

    // Abort together with a start in IDLE: the start wins.
    start(4'b1000, 2, 0, 1'b0, 1'b1, s);
    exp_q.push_back(exp_done(s, 2));
    wait_done(3);

    // Abort in LOAD of a zero delay: no done, ready again next cycle.
    start(4'b0001, 0, 0, 1'b0, 1'b0, s);
    abort = 4'b0001;
    @(negedge clk);
    abort = '0;
    chk("abort_no_done", done[0], 0);
    chk("abort_rdy", start_rdy[0], 1);
    chk("abort_busy", busy[0], 0);
    bad = 0;
    repeat (6) begin @(negedge clk); if (done[0]) bad++; end
    chk("abort_no_late_done", bad, 0);

    // Abort mid-count.
    start(4'b0100, 50, 0, 1'b0, 1'b0, s);
    repeat (20) @(negedge clk);
    abort = 4'b0100;
    @(negedge clk);
    abort = '0;
    chk("abort_count_busy", busy[2], 0);
    chk("abort_count_rdy", start_rdy[2], 1);
    bad = 0;
    repeat (250) begin @(negedge clk); if (done[2]) bad++; end
    chk("abort_count_no_done", bad, 0);

    // start_vld while busy is dropped.
    start(4'b1000, 3, 0, 1'b0, 1'b0, s);
    exp_q.push_back(exp_done(s, 3));
    @(negedge clk);
    start_min[3*DW +: DW] = '0;
    start_vld = 4'b1000;
    @(negedge clk);
    start_vld = '0;
    wait_done(3);
    bad = 0;
    repeat (30) begin @(negedge clk); if (done[3]) bad++; end
    chk("busy_start_ignored", bad, 0);

    // Random delays in [10:20] on ch2.
    hit = '0;
    for (int r = 0; r < 200; r++) begin
      start(4'b0100, 10, 20, 1'b1, 1'b0, s);
      collect(4'b0100, 300);
      chk("rand_done_seen", dcyc[2] >= 0, 1);
      if (dcyc[2] >= 0) begin
        d = ticks_in(s + 2, dcyc[2] - 1);
        chk("rand_in_range", (d >= 10) && (d <= 20), 1);
        chk("rand_timing", dcyc[2], exp_done(s, d));
        if (d >= 10 && d <= 20) hit[d - 10] = 1'b1;
      end
    end
    nhit = 0;
    for (int i = 0; i < 11; i++) if (hit[i]) nhit++;
    chk("rand_all_values_hit", nhit, 11);

    // Four channels expiring together.
    start(4'b1111, 5, 0, 1'b0, 1'b0, s);
    exp_q.push_back(exp_done(s, 5));
    while (cyc < exp_q[0] - 1) @(negedge clk);
    chk("multi_before_done", done, 0);
    @(negedge clk);
    chk("multi_done_cycle", cyc, exp_q.pop_front());
    chk("multi_done_all", done, 4'hF);
    @(negedge clk);
    chk("multi_done_cleared", done, 0);

    // Channels loading together draw distinct random delays.
    for (int r = 0; r < 100; r++) begin
      start(4'b1111, 0, 15, 1'b1, 1'b0, s);
      collect(4'b1111, 200);
      ok = 1;
      for (int c = 0; c < NCH; c++) begin
        if (dcyc[c] < 0) ok = 0;
        dv[c] = ticks_in(s + 2, dcyc[c] - 1);
        if (dv[c] > 15) ok = 0;
      end
      for (int i = 0; i < NCH; i++)
        for (int j = i + 1; j < NCH; j++)
          if (dv[i] == dv[j]) ok = 0;
      chk("rand_distinct", ok, 1);
    end

    // Reset mid-count.
    start(4'b0001, 20, 0, 1'b0, 1'b0, s);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_rdy", start_rdy, 4'hF);
    chk("midreset_ts", timestamp, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin @(negedge clk); if (done != 0) bad++; end
    chk("midreset_no_done", bad, 0);
    chk("midreset_rdy_after", start_rdy, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
